// File: rtl/p_shfrot_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : p_shfrot_iter_if
// Description : Request/response bundle for the iterative packed shift/rotate
//               unit. The master issues operations; the slave computes them.
// Revision    : 1.0 - initial release
// ============================================================================
interface p_shfrot_iter_if #(
  parameter int XLEN = 32
);
  localparam int LW = $clog2(XLEN);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] crs1;
  logic [LW-1:0]   shamt;
  logic [LW-1:0]   pw;
  logic            shift;
  logic            rotate;
  logic            arith;
  logic            left;
  logic            right;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, crs1, shamt, pw, shift, rotate, arith, left, right,
           flush, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, crs1, shamt, pw, shift, rotate, arith, left, right,
           flush, out_ready,
    output in_ready, out_valid, result
  );
endinterface
`default_nettype wire

// File: rtl/p_shfrot_iter.sv
`default_nettype none
// ============================================================================
// Module      : p_shfrot_iter
// Description : Iterative packed shift/rotate unit. Applies LPC barrel levels
//               per cycle to packed elements of width XLEN>>i selected by a
//               one-hot pack width. Supports logical shift, arithmetic right
//               shift and rotate with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module p_shfrot_iter #(
  parameter int XLEN = 32,
  parameter int LPC  = 1
) (
  input  logic               g_clk,
  input  logic               g_reset,
  p_shfrot_iter_if.slave     bus
);

  localparam int LW   = $clog2(XLEN);
  localparam int NCYC = (LW + LPC - 1) / LPC;
  localparam int CW   = $clog2(NCYC) + 1;

  localparam logic [1:0]    c_idle = 2'd0;
  localparam logic [1:0]    c_run  = 2'd1;
  localparam logic [1:0]    c_done = 2'd2;
  localparam logic [CW-1:0] c_last = CW'(NCYC - 1);

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_data;
  logic [LW-1:0]   r_shamt;
  logic [LW-1:0]   r_pw;
  logic            r_rotate;
  logic            r_arith;
  logic            r_left;

  logic            w_legal;
  logic [LW-1:0]   w_pw_scan;
  int              w_width;
  logic [XLEN-1:0] w_step;
  logic [LW-1:0]   w_sh;
  int              w_amt;

  // One barrel level of amount amt on every w-bit element. Arithmetic fill
  // samples the element MSB from the pre-level data; arith with left falls
  // through to a plain logical left shift.
  function automatic logic [XLEN-1:0] f_level(
    input logic [XLEN-1:0] d,
    input int              amt,
    input int              w,
    input logic            rot,
    input logic            ari,
    input logic            lft
  );
    logic [XLEN-1:0] q;
    int              base;
    int              off;
    int              src;
    q = '0;
    for (int j = 0; j < XLEN; j++) begin
      base = j & ~(w - 1);
      off  = j & (w - 1);
      src  = base + w - 1;
      if (amt >= w) begin
        if (rot)
          q[j[LW-1:0]] = d[j[LW-1:0]];
        else if (ari && !lft)
          q[j[LW-1:0]] = d[src[LW-1:0]];
        else
          q[j[LW-1:0]] = 1'b0;
      end else if (lft) begin
        if (off >= amt) begin
          src = j - amt;
          q[j[LW-1:0]] = d[src[LW-1:0]];
        end else if (rot) begin
          src = j - amt + w;
          q[j[LW-1:0]] = d[src[LW-1:0]];
        end else begin
          q[j[LW-1:0]] = 1'b0;
        end
      end else begin
        if (off + amt < w) begin
          src = j + amt;
          q[j[LW-1:0]] = d[src[LW-1:0]];
        end else if (rot) begin
          src = j + amt - w;
          q[j[LW-1:0]] = d[src[LW-1:0]];
        end else if (ari) begin
          q[j[LW-1:0]] = d[src[LW-1:0]];
        end else begin
          q[j[LW-1:0]] = 1'b0;
        end
      end
    end
    return q;
  endfunction

  // Encoding check at the request: one-hot width, one op, one direction
  always_comb begin
    w_legal = ($countones(bus.pw) == 1) &&
              ($countones({bus.shift, bus.rotate, bus.arith}) == 1) &&
              ($countones({bus.left, bus.right}) == 1);
  end

  // Decode captured one-hot pack width into an element width in bits
  always_comb begin
    w_width   = XLEN;
    w_pw_scan = r_pw;
    for (int i = 0; i < LW; i++) begin
      if (w_pw_scan[0])
        w_width = XLEN >> i;
      w_pw_scan = w_pw_scan >> 1;
    end
  end

  // Apply this cycle's LPC levels; r_shamt is consumed LSB-first so bit 0
  // always corresponds to the next level to evaluate
  always_comb begin
    w_step = r_data;
    w_sh   = r_shamt;
    w_amt  = 1 << (int'(r_cnt) * LPC);
    for (int l = 0; l < LPC; l++) begin
      if (w_sh[0])
        w_step = f_level(w_step, w_amt, w_width, r_rotate, r_arith, r_left);
      w_sh  = w_sh >> 1;
      w_amt = w_amt << 1;
    end
  end

  // Control FSM and datapath registers; flush overrides every state
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state  <= c_idle;
      r_cnt    <= '0;
      r_data   <= '0;
      r_shamt  <= '0;
      r_pw     <= '0;
      r_rotate <= 1'b0;
      r_arith  <= 1'b0;
      r_left   <= 1'b0;
    end else if (bus.flush) begin
      r_state <= c_idle;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (bus.in_valid) begin
            // An illegal request runs on zero data, which every level maps to zero
            r_data   <= w_legal ? bus.crs1 : '0;
            r_shamt  <= bus.shamt;
            r_pw     <= bus.pw;
            r_rotate <= bus.rotate;
            r_arith  <= bus.arith;
            r_left   <= bus.left;
            r_cnt    <= '0;
            r_state  <= c_run;
          end
        end
        c_run: begin
          r_data  <= w_step;
          r_shamt <= r_shamt >> LPC;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == c_last)
            r_state <= c_done;
        end
        c_done: begin
          if (bus.out_ready)
            r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == c_idle);
  assign bus.out_valid = (r_state == c_done);
  assign bus.result    = (r_state == c_done) ? r_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_p_shfrot_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_p_shfrot_iter
// Description : Bench for p_shfrot_iter; a 32-bit/LPC=1 and a 64-bit/LPC=3
//               instance share one stimulus bus selected by sel64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_p_shfrot_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel64;
  logic        in_valid, flush, out_ready;
  logic [63:0] crs1;
  logic [5:0]  shamt, pw;
  logic        shift, rotate, arith, left, right;
  logic        rdy, val;
  logic [63:0] res;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  p_shfrot_iter_if #(.XLEN(32)) a32 ();
  p_shfrot_iter_if #(.XLEN(64)) a64 ();

  p_shfrot_iter #(.XLEN(32), .LPC(1)) dut32 (.g_clk(clk), .g_reset(rst), .bus(a32));
  p_shfrot_iter #(.XLEN(64), .LPC(3)) dut64 (.g_clk(clk), .g_reset(rst), .bus(a64));

  assign a32.in_valid  = in_valid & ~sel64;
  assign a32.flush     = flush & ~sel64;
  assign a32.out_ready = out_ready;
  assign a32.crs1      = crs1[31:0];
  assign a32.shamt     = shamt[4:0];
  assign a32.pw        = pw[4:0];
  assign a32.shift     = shift;
  assign a32.rotate    = rotate;
  assign a32.arith     = arith;
  assign a32.left      = left;
  assign a32.right     = right;

  assign a64.in_valid  = in_valid & sel64;
  assign a64.flush     = flush & sel64;
  assign a64.out_ready = out_ready;
  assign a64.crs1      = crs1;
  assign a64.shamt     = shamt;
  assign a64.pw        = pw;
  assign a64.shift     = shift;
  assign a64.rotate    = rotate;
  assign a64.arith     = arith;
  assign a64.left      = left;
  assign a64.right     = right;

  assign rdy = sel64 ? a64.in_ready  : a32.in_ready;
  assign val = sel64 ? a64.out_valid : a32.out_valid;
  assign res = sel64 ? a64.result    : {32'd0, a32.result};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Element-wise reference: ops = {shift, rotate, arith, left, right}
  function automatic logic [63:0] model(input int xlen, input logic [63:0] x,
                                        input int sh, input logic [5:0] p,
                                        input logic [4:0] ops);
    int          lw, w, m;
    logic [63:0] mask, e, se, o, r;
    lw = (xlen == 64) ? 6 : 5;
    if ($countones(p) != 1 || $countones(ops[4:2]) != 1 || $countones(ops[1:0]) != 1)
      return 64'd0;
    w = xlen;
    for (int i = 0; i < lw; i++) if (p[i]) w = xlen >> i;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    r = 64'd0;
    for (int b = 0; b < xlen; b += w) begin
      e = (x >> b) & mask;
      m = sh;
      if (ops[3]) begin
        m = m % w;
        if (m == 0) o = e;
        else if (ops[1]) o = ((e << m) | (e >> (w - m))) & mask;
        else             o = ((e >> m) | (e << (w - m))) & mask;
      end else if (ops[2] && ops[0]) begin
        se = (((e >> (w - 1)) & 64'd1) != 0) ? (e | ~mask) : e;
        if (m >= w) m = w - 1;
        o = 64'($signed(se) >>> m) & mask;
      end else begin
        if (m >= w) o = 64'd0;
        else o = ops[1] ? ((e << m) & mask) : (e >> m);
      end
      r = r | (o << b);
    end
    return r;
  endfunction

  task automatic set_req(input logic [63:0] x, input int sh, input logic [5:0] p,
                         input logic [4:0] ops);
    crs1  = x;
    shamt = 6'(sh);
    pw    = p;
    {shift, rotate, arith, left, right} = ops;
  endtask

  // Waits for out_valid counting negedges since the accept edge
  task automatic wait_done(input int ncyc, input logic [63:0] exp, output logic [63:0] got);
    int lat;
    lat = 0;
    while (!val && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(ncyc));
    got = res;
    check("result", res, exp);
  endtask

  task automatic do_op(input bit is64, input logic [63:0] x, input int sh,
                       input logic [5:0] p, input logic [4:0] ops,
                       output logic [63:0] got);
    int          xl;
    logic [63:0] xm;
    xl = is64 ? 64 : 32;
    xm = is64 ? x : {32'd0, x[31:0]};
    @(negedge clk);
    sel64 = is64;
    set_req(xm, sh, p, ops);
    #1;
    check("in_ready", {63'd0, rdy}, 64'd1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(is64 ? 2 : 5, model(xl, xm, sh, p, ops), got);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("back_idle", {62'd0, val, rdy}, 64'd1);
  endtask

  initial begin : main
    logic [63:0] got, x;
    logic [5:0]  p;
    logic [4:0]  ops;
    bit          is64;
    int          lw, sh, seen;

    rst = 1'b1; sel64 = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_req(64'd0, 0, 6'd1, 5'b10010);
    repeat (3) @(negedge clk);
    check("rst32", {61'd0, rdy, val, res != 64'd0}, 64'b100);
    sel64 = 1'b1; #1;
    check("rst64", {61'd0, rdy, val, res != 64'd0}, 64'b100);
    @(negedge clk); rst = 1'b0;

    // Directed cases
    do_op(0, 64'h8001_4000, 1, 6'b00010, 5'b01010, got);
    check("t1", got, 64'h0003_8000);
    do_op(0, 64'h807F_F010, 3, 6'b00100, 5'b00101, got);
    check("t2a", got, 64'hF00F_FE02);
    do_op(0, 64'h807F_F010, 3, 6'b00100, 5'b10001, got);
    check("t2s", got, 64'h100F_1E02);
    do_op(0, 64'hFFFF_FFFF, 4, 6'b01000, 5'b10010, got);
    check("t3s", got, 64'h0);
    do_op(0, 64'hFFFF_FFFF, 4, 6'b01000, 5'b01010, got);
    check("t3r", got, 64'hFFFF_FFFF);
    do_op(0, 64'h8888_8888, 4, 6'b01000, 5'b00101, got);
    check("t3a", got, 64'hFFFF_FFFF);
    do_op(1, 64'h0123_4567_89AB_CDEF, 36, 6'b000001, 5'b01001, got);
    check("t6", got, 64'h789A_BCDE_F012_3456);
    do_op(1, 64'h0123_4567_89AB_CDEF, 36, 6'b000011, 5'b01001, got);
    check("t6ill", got, 64'h0);
    do_op(0, 64'hDEAD_BEEF, 2, 6'b00010, 5'b11010, got);
    check("ill_op", got, 64'h0);

    // Backpressure: DONE holds for 3 cycles while a new request waits
    @(negedge clk);
    sel64 = 1'b0;
    set_req(64'h8001_4000, 1, 6'b00010, 5'b01010);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(5, 64'h0003_8000, got);
    set_req(64'h1234_5678, 5, 6'b00001, 5'b10010);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_result", res, 64'h0003_8000);
      check("bp_state", {62'd0, val, rdy}, 64'b10);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle", {62'd0, val, rdy}, 64'b01);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accept", {62'd0, val, rdy}, 64'b00);
    wait_done(5, 64'h468A_CF00, got);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Flush on the second RUN cycle
    set_req(64'hCAFE_F00D, 31, 6'b00001, 5'b01010);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", {62'd0, val, rdy}, 64'b01);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (val) seen++;
    end
    check("flush_noval", 64'(seen), 64'd0);
    check("flush_res", res, 64'd0);

    // Asynchronous reset mid-RUN
    set_req(64'hFFFF_0000, 7, 6'b00001, 5'b01001);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst", {62'd0, val, res != 64'd0}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("arst_idle", {63'd0, rdy}, 64'd1);

    // Randomized operations, mostly legal encodings
    for (int n = 0; n < 150; n++) begin
      is64 = 1'($urandom_range(0, 1));
      lw   = is64 ? 6 : 5;
      x    = {$urandom, $urandom};
      sh   = $urandom_range(0, (1 << lw) - 1);
      if ($urandom_range(0, 9) < 8) begin
        p = 6'd1 << $urandom_range(0, lw - 1);
        case ($urandom_range(0, 2))
          0:       ops[4:2] = 3'b100;
          1:       ops[4:2] = 3'b010;
          default: ops[4:2] = 3'b001;
        endcase
        ops[1:0] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      end else begin
        p   = 6'($urandom) & (is64 ? 6'h3F : 6'h1F);
        ops = 5'($urandom);
      end
      do_op(is64, x, sh, p, ops, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
